// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_seq
//  Purpose  : Sequential AES MixColumns engine (forward / inverse / bypass),
//             LANES columns per clock, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int         BEATS     = 4 / LANES;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_columns_seq: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_fsm, w_fsm_next;
  logic [127:0]   r_state;
  logic           r_inv;
  logic [1:0]     r_cnt;
  logic           w_accept;

  logic [1:0]     w_col_idx [LANES];
  logic [31:0]    w_col_in  [LANES];
  logic [31:0]    w_col_out [LANES];

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns of one column; a0 is the top byte.
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3),
            (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Inverse MixColumns; 9/B/D/E multiples come from chained xtime terms.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    {a[0], a[1], a[2], a[3]} = c;
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // One transform unit per lane; each beat walks it to the next column group.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_col_idx[l] = 2'(r_cnt * LANES + l);
    assign w_col_in[l]  = r_state[127 - 32*w_col_idx[l] -: 32];
    assign w_col_out[l] = r_inv ? mix_inv(w_col_in[l]) : mix_fwd(w_col_in[l]);
  end

  assign out_data = r_state;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // Next-state and handshake outputs; DONE can hand over straight to a new block.
  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_fsm)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        busy = 1'b1;
        if (r_cnt == LAST_BEAT) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_fsm_next = IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    w_accept = in_valid && in_ready;
    if (w_accept) w_fsm_next = in_mode[1] ? DONE : BUSY;
  end

  // State register capture on accept, in-place column update while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= in_data;
      r_inv   <= (in_mode == 2'b01);
      r_cnt   <= '0;
    end else if (r_fsm == BUSY) begin
      for (int l = 0; l < LANES; l++) begin
        r_state[127 - 32*w_col_idx[l] -: 32] <= w_col_out[l];
      end
      r_cnt <= (r_cnt == LAST_BEAT) ? 2'd0 : r_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_columns_seq
//  Purpose  : Self-checking bench for mix_columns_seq; one instance each for
//             LANES = 1, 2, 4, checked against a GF(2^8) matrix model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic [1:0]   in_mode   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  mix_columns_seq #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
  mix_columns_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply, polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product per column; bypass modes pass the state through.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] m);
    logic [7:0] fwd [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] inv [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    logic [7:0] a [4];
    logic [7:0] y;
    logic [127:0] r = '0;
    if (m[1]) return s;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        y = 8'h00;
        for (int j = 0; j < 4; j++)
          y ^= gmul(m[0] ? inv[(j - row) & 3] : fwd[(j - row) & 3], a[j]);
        r[127 - 32*c - 8*row -: 8] = y;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present one block on instance k, measure latency / busy cycles, take the result.
  task automatic do_block(input int k, input logic [127:0] d, input logic [1:0] m,
                          output logic [127:0] res);
    logic [127:0] exp;
    int n, lat, bc, beats;
    beats = 4 >> k;
    exp   = ref_mix(d, m);
    in_data[k] = d; in_mode[k] = m; in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 20) begin @(posedge clk); #1; n++; end
    check($sformatf("L%0d in_ready before accept", 1 << k), 128'(in_ready[k]), 128'd1);
    @(posedge clk); #1;
    // Scramble the inputs: the latched mode and captured data must not follow them.
    in_valid[k] = 1'b0; in_mode[k] = ~m; in_data[k] = rnd128();
    lat = 0; bc = 0;
    while (!out_valid[k] && lat < 20) begin
      bc += int'(busy[k]);
      @(posedge clk); #1; lat++;
    end
    // Bypass results are presented in the cycle right after the accept edge.
    check($sformatf("L%0d latency mode %0d", 1 << k, m), 128'(lat), 128'(m[1] ? 0 : beats));
    check($sformatf("L%0d busy cycles mode %0d", 1 << k, m), 128'(bc), 128'(m[1] ? 0 : beats));
    check($sformatf("L%0d out_data mode %0d", 1 << k, m), out_data[k], exp);
    res = out_data[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check($sformatf("L%0d out_valid after take", 1 << k), 128'(out_valid[k]), 128'd0);
  endtask

  task automatic do_vec(input int k, input logic [127:0] d, input logic [1:0] m,
                        input logic [127:0] golden, input string tag);
    logic [127:0] res;
    do_block(k, d, m, res);
    check(tag, res, golden);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, r1, r2, held;
    int lat;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_mode[k] = 2'b00; out_ready[k] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("L%0d reset in_ready", 1 << k), 128'(in_ready[k]), 128'd0);
      check($sformatf("L%0d reset out_valid", 1 << k), 128'(out_valid[k]), 128'd0);
      check($sformatf("L%0d reset out_data", 1 << k), out_data[k], 128'd0);
      check($sformatf("L%0d reset busy", 1 << k), 128'(busy[k]), 128'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("L%0d in_ready after reset", 1 << k), 128'(in_ready[k]), 128'd1);

    // Known-answer vectors.
    do_vec(2, {32'hdb135345, 96'h0}, 2'b00, {32'h8e4da1bc, 96'h0}, "L4 fwd vector");
    do_vec(0, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 2'b00,
              128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6, "L1 fwd vector");
    do_vec(1, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 2'b01,
              128'hdb135345_f20a225c_d4d4d4d5_2d26314c, "L2 inv vector");
    for (int k = 0; k < 3; k++) begin
      do_vec(k, 128'h00112233445566778899aabbccddeeff, 2'b10,
                128'h00112233445566778899aabbccddeeff, "bypass 10 vector");
      do_vec(k, 128'h00112233445566778899aabbccddeeff, 2'b11,
                128'h00112233445566778899aabbccddeeff, "bypass 11 vector");
    end

    // Forward then inverse round trip.
    for (int k = 0; k < 3; k++) begin
      a = rnd128();
      do_block(k, a, 2'b00, r1);
      do_block(k, r1, 2'b01, r2);
      check($sformatf("L%0d round trip", 1 << k), r2, a);
    end

    // Random blocks and modes.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 6; i++) do_block(k, rnd128(), 2'($urandom_range(0, 3)), r1);

    // Stall in DONE with a pending block, then hand over without a bubble.
    a = rnd128(); b = rnd128();
    in_data[1] = a; in_mode[1] = 2'b00; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b first result", out_data[1], ref_mix(a, 2'b00));
    held = out_data[1];
    in_data[1] = b; in_mode[1] = 2'b01; in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall in_ready", 128'(in_ready[1]), 128'd0);
      check("stall out_valid", 128'(out_valid[1]), 128'd1);
      check("stall out_data", out_data[1], held);
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    #1;
    check("b2b in_ready in DONE", 128'(in_ready[1]), 128'd1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    check("b2b second busy", 128'(busy[1]), 128'd1);
    check("b2b out_valid drop", 128'(out_valid[1]), 128'd0);
    lat = 0;
    while (!out_valid[1] && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b second latency", 128'(lat), 128'd2);
    check("b2b second result", out_data[1], ref_mix(b, 2'b01));
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // Reset on the second busy cycle of a LANES=1 block.
    in_data[0] = rnd128(); in_mode[0] = 2'b00; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("abort busy before reset", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort out_valid", 128'(out_valid[0]), 128'd0);
    check("abort out_data", out_data[0], 128'd0);
    check("abort busy", 128'(busy[0]), 128'd0);
    check("abort in_ready in reset", 128'(in_ready[0]), 128'd0);
    rst = 1'b0;
    #1;
    check("abort in_ready idle", 128'(in_ready[0]), 128'd1);
    do_block(0, rnd128(), 2'b01, r1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
